tape_port_arbiter: RTL and testbench
====================================

TAPE_PORT_ARBITER -- requirements
Module: tape_port_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 15, tape address width; DATA_W, default 8, cell width; MAX_CPU_WAIT, default 6, CPU wait cycles before forced CPU grant.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 in_display_area  in  1  scanout active; VGA fetches only when 1.
REQ-005 vga_addr  in  ADDR_W  tape cell address wanted by scanout.
REQ-006 vga_cell  out  DATA_W  last fetched scanout cell, held between fetches.
REQ-007 cpu_req  in  1  CPU access request, held until ack.
REQ-008 cpu_we  in  1  1=write, 0=read; stable while cpu_req=1.
REQ-009 cpu_addr  in  ADDR_W  CPU address; stable while cpu_req=1.
REQ-010 cpu_wdata  in  DATA_W  write data; stable while cpu_req=1.
REQ-011 cpu_ack  out  1  one-cycle completion pulse.
REQ-012 cpu_rdata  out  DATA_W  read data, valid in the cpu_ack cycle of a read, held after.
REQ-013 mem_addr  out  ADDR_W  single-port tape RAM address.
REQ-014 mem_we  out  1  RAM write enable.
REQ-015 mem_wdata  out  DATA_W  RAM write data.
REQ-016 mem_rdata  in  DATA_W  RAM read data, valid one cycle after address (synchronous RAM).
REQ-017 vga_late  out  16  saturating count of VGA fetches delayed by forced CPU grants.

Function
REQ-018 Exactly one grant per cycle: NONE, VGA or CPU; mem_addr/mem_we/mem_wdata shall be combinational from the grant (NONE: mem_we=0, mem_addr=0).
REQ-019 VGA pending shall be 1 when in_display_area=1 and (last_vga_valid=0 or vga_addr != last_vga_addr).
REQ-020 CPU eligible shall be 1 when cpu_req=1 and no CPU access is in flight.
REQ-021 Priority: if CPU eligible and cpu_wait >= MAX_CPU_WAIT -> CPU; else VGA pending -> VGA; else CPU eligible -> CPU; else NONE.
REQ-022 cpu_wait shall increment each cycle CPU is eligible but not granted, saturate at MAX_CPU_WAIT, and clear on CPU grant.
REQ-023 vga_late shall increment (saturating at 65535) on each cycle where VGA is pending and CPU is granted by the forced rule.
REQ-024 VGA grant in cycle N: last_vga_addr<=vga_addr, last_vga_valid<=1 at end of N; vga_cell<=mem_rdata at end of N+1.
REQ-025 CPU write grant in cycle N: mem_we=1 in N only; cpu_ack=1 in N+1.
REQ-026 CPU read grant in cycle N: cpu_rdata<=mem_rdata at end of N+1; cpu_ack=1 in N+2.
REQ-027 In-flight window runs from grant cycle through ack cycle inclusive; cpu_req during it shall not produce a grant.
REQ-028 cpu_req=1 in the cycle after cpu_ack shall be treated as a new request.
REQ-029 in_display_area=0 shall suppress VGA pending; vga_cell holds; last_vga_valid unchanged.
REQ-030 VGA and CPU targeting the same address: grants serialize per REQ-021; CPU write before VGA read returns new data.
REQ-031 No combinational path from mem_rdata to any output; vga_cell, cpu_rdata, cpu_ack are registers.

Reset
REQ-032 On reset=1: vga_cell=0, cpu_rdata=0, cpu_ack=0, vga_late=0, cpu_wait=0, last_vga_valid=0, in-flight cleared, grant NONE.
REQ-033 Reset mid-access shall discard the pending ack/data; no cpu_ack after release for a pre-reset grant.
REQ-034 First cycle after release with in_display_area=1 shall issue a VGA fetch regardless of vga_addr.

Verification
REQ-035 vga_addr steps every 8 cycles, cpu_req idle, RAM[a]=a[7:0] -> VGA grant on each change, vga_cell=addr[7:0] two cycles later, vga_late=0.
REQ-036 CPU write 0x5A to 0x0100, no display -> mem_we=1 one cycle, cpu_ack next cycle; following read of 0x0100 -> cpu_ack 2 cycles after grant, cpu_rdata=0x5A.
REQ-037 vga_addr changes every cycle, cpu_req held, MAX_CPU_WAIT=6 -> CPU granted after 6 waiting cycles, vga_late=1.
REQ-038 Simultaneous VGA change and cpu_req with cpu_wait=0 -> VGA granted first, CPU next cycle, ack per REQ-025/026.
REQ-039 Assert reset in the cycle after a CPU read grant -> no cpu_ack, all outputs 0; after release first display cycle fetches vga_addr.
REQ-040 cpu_req held high across ack -> exactly one grant per request, second grant no earlier than the cycle after cpu_ack.

Source files
------------

// File: rtl/tape_port_arbiter.sv
// Single-port tape RAM arbiter shared by VGA scanout and the CPU.
// Scanout normally wins; a CPU that has waited MAX_CPU_WAIT cycles is forced through.
module tape_port_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 8,
  parameter int MAX_CPU_WAIT = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_display_area,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_cell,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       vga_late
);

  localparam int WAIT_W = $clog2(MAX_CPU_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_CPU_WAIT);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_CPU  = 2'd2
  } grant_t;

  grant_t              grant_s;
  logic                vga_pending_s;
  logic                cpu_elig_s;
  logic                cpu_forced_s;

  logic [ADDR_W-1:0]   last_vga_addr_r;
  logic                last_vga_valid_r;
  logic                busy_r;
  logic [WAIT_W-1:0]   cpu_wait_r;
  logic                vga_fetch_r;
  logic                cpu_rd_fetch_r;
  logic [DATA_W-1:0]   vga_cell_r;
  logic [DATA_W-1:0]   cpu_rdata_r;
  logic                cpu_ack_r;
  logic [15:0]         vga_late_r;

  // Grant decision: forced CPU, then scanout, then ordinary CPU.
  always_comb begin
    vga_pending_s = in_display_area & (~last_vga_valid_r | (vga_addr != last_vga_addr_r));
    cpu_elig_s    = cpu_req & ~busy_r;
    cpu_forced_s  = cpu_elig_s & (cpu_wait_r >= WAIT_MAX);
    grant_s       = GNT_NONE;
    if (reset) begin
      grant_s = GNT_NONE;
    end else if (cpu_forced_s) begin
      grant_s = GNT_CPU;
    end else if (vga_pending_s) begin
      grant_s = GNT_VGA;
    end else if (cpu_elig_s) begin
      grant_s = GNT_CPU;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // RAM port steering from the current grant.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (grant_s)
      GNT_VGA: begin
        mem_addr = vga_addr;
      end
      GNT_CPU: begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
      end
      default: begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
      end
    endcase
  end

  // Arbitration state, read-data capture and ack generation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_vga_addr_r  <= '0;
      last_vga_valid_r <= 1'b0;
      busy_r           <= 1'b0;
      cpu_wait_r       <= '0;
      vga_fetch_r      <= 1'b0;
      cpu_rd_fetch_r   <= 1'b0;
      vga_cell_r       <= '0;
      cpu_rdata_r      <= '0;
      cpu_ack_r        <= 1'b0;
      vga_late_r       <= 16'd0;
    end else begin
      vga_fetch_r    <= (grant_s == GNT_VGA);
      cpu_rd_fetch_r <= (grant_s == GNT_CPU) && !cpu_we;
      // Writes ack one cycle after grant; reads ack once the RAM data is captured.
      cpu_ack_r      <= ((grant_s == GNT_CPU) && cpu_we) || cpu_rd_fetch_r;

      if (grant_s == GNT_VGA) begin
        last_vga_addr_r  <= vga_addr;
        last_vga_valid_r <= 1'b1;
      end
      if (vga_fetch_r) begin
        vga_cell_r <= mem_rdata;
      end
      if (cpu_rd_fetch_r) begin
        cpu_rdata_r <= mem_rdata;
      end

      if (grant_s == GNT_CPU) begin
        busy_r <= 1'b1;
      end else if (cpu_ack_r) begin
        busy_r <= 1'b0;
      end

      if (grant_s == GNT_CPU) begin
        cpu_wait_r <= '0;
      end else if (cpu_elig_s && (cpu_wait_r < WAIT_MAX)) begin
        cpu_wait_r <= cpu_wait_r + WAIT_W'(1);
      end

      if (cpu_forced_s && vga_pending_s && (vga_late_r != 16'hFFFF)) begin
        vga_late_r <= vga_late_r + 16'd1;
      end
    end
  end

  assign vga_cell  = vga_cell_r;
  assign cpu_rdata = cpu_rdata_r;
  assign cpu_ack   = cpu_ack_r;
  assign vga_late  = vga_late_r;

endmodule

// File: tb/tb_tape_port_arbiter.sv
// Bench for tape_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a cycle-indexed event model of the arbiter.
module tb_tape_port_arbiter;
  localparam int AW   = 15;
  localparam int DW   = 8;
  localparam int MAXW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_display_area;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_cell;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   vga_late;

  always #5 clk = ~clk;

  tape_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CPU_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .in_display_area(in_display_area), .vga_addr(vga_addr),
    .vga_cell(vga_cell), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .vga_late(vga_late)
  );

  // Synchronous tape RAM; unwritten cells read back as their low address byte.
  logic [DW-1:0] ram    [0:(1<<AW)-1];
  bit            ram_wr [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : mem_addr[7:0];
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int vis; logic [7:0] val; } vev_t;
  vev_t          vq[$];
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  bit            m_wr  [0:(1<<AW)-1];
  logic [AW-1:0] m_last;
  bit            m_valid;
  int            m_wait, m_ack_cyc, m_rd_cyc, e_late;
  logic [7:0]    m_rd_val, e_vga, e_rdata;

  function automatic logic [7:0] m_rd(input logic [AW-1:0] a);
    return m_wr[a] ? m_mem[a] : a[7:0];
  endfunction

  task automatic model_reset();
    vq.delete();
    m_valid = 1'b0; m_last = '0; m_wait = 0;
    m_ack_cyc = -1; m_rd_cyc = -1; m_rd_val = 8'h00;
    e_late = 0; e_vga = 8'h00; e_rdata = 8'h00;
  endtask

  // staged inputs, applied at the falling edge
  logic          s_reset, s_disp, s_req, s_we;
  logic [AW-1:0] s_vaddr, s_caddr;
  logic [DW-1:0] s_wdata;

  task automatic step();
    bit   pend, elig, forced;
    int   g;
    logic [AW-1:0] ea;
    vev_t ev;
    @(negedge clk);
    reset = s_reset; in_display_area = s_disp; vga_addr = s_vaddr;
    cpu_req = s_req; cpu_we = s_we; cpu_addr = s_caddr; cpu_wdata = s_wdata;
    #1;
    if (reset) begin
      model_reset();
      chk("rst_vga_cell", vga_cell, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_vga_late", vga_late, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
    end else begin
      while (vq.size() > 0 && vq[0].vis <= cyc) begin
        e_vga = vq[0].val;
        void'(vq.pop_front());
      end
      if (cyc == m_rd_cyc) e_rdata = m_rd_val;
      chk("vga_cell", vga_cell, e_vga);
      chk("cpu_rdata", cpu_rdata, e_rdata);
      chk("cpu_ack", cpu_ack, (cyc == m_ack_cyc) ? 1 : 0);
      chk("vga_late", vga_late, e_late);

      pend   = in_display_area && (!m_valid || vga_addr != m_last);
      elig   = cpu_req && (cyc > m_ack_cyc);
      forced = elig && (m_wait >= MAXW);
      if (forced)    g = 2;
      else if (pend) g = 1;
      else if (elig) g = 2;
      else           g = 0;
      ea = (g == 1) ? vga_addr : (g == 2) ? cpu_addr : '0;
      chk("mem_addr", mem_addr, ea);
      chk("mem_we", mem_we, (g == 2 && cpu_we) ? 1 : 0);
      if (g == 2 && cpu_we) chk("mem_wdata", mem_wdata, cpu_wdata);

      if (g == 2) begin
        m_wait = 0;
        m_ack_cyc = cyc + (cpu_we ? 1 : 2);
        if (cpu_we) begin
          m_mem[cpu_addr] = cpu_wdata;
          m_wr[cpu_addr]  = 1'b1;
        end else begin
          m_rd_cyc = cyc + 2;
          m_rd_val = m_rd(cpu_addr);
        end
        if (forced && pend && e_late < 65535) e_late++;
      end else if (elig && m_wait < MAXW) begin
        m_wait++;
      end
      if (g == 1) begin
        ev.vis = cyc + 2;
        ev.val = m_rd(vga_addr);
        vq.push_back(ev);
        m_last = vga_addr;
        m_valid = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    s_reset = 1'b1; s_req = 1'b0;
    step();
    s_reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int gi, n, mode, outstanding;
    logic [AW-1:0] va;
    reset = 1'b1; in_display_area = 1'b0; vga_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    s_reset = 1'b1; s_disp = 1'b0; s_req = 1'b0; s_we = 1'b0;
    s_vaddr = '0; s_caddr = '0; s_wdata = '0;
    model_reset();
    do_reset();

    // scanout stepping every 8 cycles, CPU idle
    s_disp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      va = 15'h0200 + 15'(k * 17);
      s_vaddr = va;
      for (int j = 0; j < 8; j++) begin
        step();
        if (j == 0) chk("req035_grant", mem_addr, va);
        if (j == 1) chk("req035_idle", mem_addr, 0);
        if (j == 2) chk("req035_cell", vga_cell, va[7:0]);
      end
    end
    chk("req035_late", vga_late, 0);

    // CPU write then read of 0x0100 outside the display area
    s_disp = 1'b0; s_req = 1'b1; s_we = 1'b1; s_caddr = 15'h0100; s_wdata = 8'h5A;
    step();
    chk("req036_we", mem_we, 1);
    chk("req036_waddr", mem_addr, 15'h0100);
    step();
    chk("req036_wack", cpu_ack, 1);
    chk("req036_we_off", mem_we, 0);
    s_we = 1'b0;
    step();
    chk("req036_raddr", mem_addr, 15'h0100);
    step();
    chk("req036_noack", cpu_ack, 0);
    step();
    chk("req036_rack", cpu_ack, 1);
    chk("req036_rdata", cpu_rdata, 8'h5A);
    s_req = 1'b0;
    step();

    // starving CPU is forced through after MAX_CPU_WAIT cycles
    do_reset();
    s_disp = 1'b1; s_req = 1'b1; s_we = 1'b0; s_caddr = 15'h7000;
    gi = -1;
    for (int i = 0; i < 9; i++) begin
      s_vaddr = 15'h0010 + 15'(i);
      step();
      if (gi < 0 && mem_addr == 15'h7000) gi = i;
      if (i == 8) chk("req037_ack", cpu_ack, 1);
    end
    s_req = 1'b0;
    chk("req037_grant_cycle", gi, 6);
    chk("req037_late", vga_late, 1);

    // simultaneous scanout change and CPU write: scanout first
    s_vaddr = 15'h0040; s_req = 1'b1; s_we = 1'b1; s_caddr = 15'h0300; s_wdata = 8'hC3;
    step();
    chk("req038_vga_first", mem_addr, 15'h0040);
    step();
    chk("req038_cpu_next", mem_addr, 15'h0300);
    chk("req038_cpu_we", mem_we, 1);
    step();
    chk("req038_ack", cpu_ack, 1);
    s_req = 1'b0;
    s_vaddr = 15'h0300;
    step(); step(); step();
    chk("req030_new_data", vga_cell, 8'hC3);

    // reset right after a read grant drops the access
    s_disp = 1'b0; s_req = 1'b1; s_we = 1'b0; s_caddr = 15'h0100;
    step();
    chk("req039_grant", mem_addr, 15'h0100);
    s_reset = 1'b1; s_req = 1'b0;
    step();
    chk("req039_rst_rdata", cpu_rdata, 0);
    chk("req039_rst_cell", vga_cell, 0);
    s_reset = 1'b0; s_disp = 1'b1;
    step();
    chk("req039_first_fetch", mem_addr, 15'h0300);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("req039_no_ack", cpu_ack, 0);
    end

    // request held across acks: one grant per request, spaced by the ack
    s_disp = 1'b0; s_req = 1'b1; s_we = 1'b0; s_caddr = 15'h0123;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (mem_addr == 15'h0123) begin
        n++;
        chk("req040_grant_slot", i % 3, 0);
      end
    end
    s_req = 1'b0;
    chk("req040_grants", n, 3);
    step();

    // randomized traffic
    outstanding = 0; mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) mode = $urandom_range(0, 2);
      if ($urandom_range(0, 299) == 0) begin
        s_reset = 1'b1; s_req = 1'b0; outstanding = 0;
      end else begin
        s_reset = 1'b0;
      end
      if ($urandom_range(0, 19) == 0) s_disp = ~s_disp;
      if (mode == 0 || (mode == 1 && i % 8 == 0) || (mode == 2 && $urandom_range(0, 3) == 0))
        s_vaddr = 15'h0020 + 15'($urandom_range(0, 15));
      if (!s_reset && outstanding == 0) begin
        if ($urandom_range(0, 9) < 4) begin
          s_req = 1'b1; s_we = 1'($urandom_range(0, 1));
          s_caddr = 15'h0020 + 15'($urandom_range(0, 15));
          s_wdata = 8'($urandom_range(0, 255));
          outstanding = 1;
        end else begin
          s_req = 1'b0;
        end
      end
      step();
      if (!s_reset && cpu_ack) outstanding = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
